// File: rtl/led_thermo_decoder.sv
// Receive-side decoder for the active-low thermometer LED bus: synchronise, de-glitch, decode level, count wraps.
// Optional sequence checker enabled by defining LED_THERMO_SEQ_CHECK_EN; otherwise seq_err is tied low.
module led_thermo_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int WRAP_W        = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        led_in,
    output logic [3:0]        level,
    output logic              level_valid,
    output logic              invalid_err,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              seq_err
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [7:0]       s1;
    logic [7:0]       s2;
    logic [7:0]       candidate;
    logic [7:0]       acc_raw;
    logic [CNT_W-1:0] stab_cnt;

    logic [7:0] inv;
    logic       is_thermo;
    logic [3:0] k;
    logic       accept;

    // Active-low bus: inverted pattern must be a contiguous run of ones from bit 0.
    always_comb begin
        inv       = ~candidate;
        is_thermo = ((inv & (inv + 8'd1)) == 8'd0);
        k         = 4'd0;
        for (int i = 0; i < 8; i++) begin
            k = k + {3'b000, inv[i]};
        end
    end

    assign accept = (s2 == candidate) && (stab_cnt == STAB_MAX) && (candidate != acc_raw);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1          <= 8'hFF;
            s2          <= 8'hFF;
            candidate   <= 8'hFF;
            acc_raw     <= 8'hFF;
            stab_cnt    <= '0;
            level       <= 4'd0;
            level_valid <= 1'b0;
            invalid_err <= 1'b0;
            wrap_cnt    <= '0;
        end else begin
            s1          <= led_in;
            s2          <= s1;
            level_valid <= 1'b0;
            invalid_err <= 1'b0;
            if (s2 != candidate) begin
                candidate <= s2;
                stab_cnt  <= '0;
            end else if (stab_cnt != STAB_MAX) begin
                stab_cnt <= stab_cnt + CNT_W'(1);
            end else if (candidate != acc_raw) begin
                acc_raw <= candidate;
                if (is_thermo) begin
                    level       <= k;
                    level_valid <= 1'b1;
                    if ((k == 4'd0) && (level == 4'd8)) begin
                        wrap_cnt <= wrap_cnt + {{(WRAP_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    invalid_err <= 1'b1;
                end
            end
        end
    end

`ifdef LED_THERMO_SEQ_CHECK_EN
    logic [3:0] exp_next;

    // level only moves on valid accepts, so it already is the previous valid level.
    assign exp_next = (level == 4'd8) ? 4'd0 : level + 4'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_err <= 1'b0;
        end else begin
            seq_err <= accept && is_thermo && (k != exp_next);
        end
    end
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_led_thermo_decoder.sv
// Directed bench for led_thermo_decoder; hand-computed expectations with immediate assertions.
module tb_led_thermo_decoder;

    logic       clk;
    logic       reset_n;
    logic [7:0] led_in;
    logic [3:0] level;
    logic       level_valid;
    logic       invalid_err;
    logic [7:0] wrap_cnt;
    logic       seq_err;

    int n_vec;
    int n_err;
    int cnt_lv;
    int cnt_ie;
    int cnt_se;
    int cnt_both;

`ifdef LED_THERMO_SEQ_CHECK_EN
    localparam int SEQ_ON = 1;
`else
    localparam int SEQ_ON = 0;
`endif

    led_thermo_decoder #(.STABLE_CYCLES(4), .WRAP_W(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .led_in      (led_in),
        .level       (level),
        .level_valid (level_valid),
        .invalid_err (invalid_err),
        .wrap_cnt    (wrap_cnt),
        .seq_err     (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (level_valid) cnt_lv = cnt_lv + 1;
        if (invalid_err) cnt_ie = cnt_ie + 1;
        if (seq_err) cnt_se = cnt_se + 1;
        if (level_valid && invalid_err) cnt_both = cnt_both + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_vec = n_vec + 1;
        assert (obs === exp_v) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic hold(input logic [7:0] p, input int n);
        @(negedge clk);
        led_in = p;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        led_in  = 8'hFF;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [7:0] seq_pat [9];
    int b_lv, b_ie, b_se, first_hit;

    initial begin
        n_vec = 0; n_err = 0;
        cnt_lv = 0; cnt_ie = 0; cnt_se = 0; cnt_both = 0;
        seq_pat = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'hFF};

        // 1: reset with garbage on the bus
        reset_n = 1'b0;
        led_in  = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        chk("t1_level", level, 0);
        chk("t1_lv", level_valid, 0);
        chk("t1_ie", invalid_err, 0);
        chk("t1_wrap", wrap_cnt, 0);
        chk("t1_seq", seq_err, 0);
        b_lv = cnt_lv; b_ie = cnt_ie;
        @(negedge clk);
        led_in  = 8'hFF;
        reset_n = 1'b1;
        hold(8'hFF, 10);
        chk("t1_idle_lv", cnt_lv - b_lv, 0);
        chk("t1_idle_ie", cnt_ie - b_ie, 0);

        // 2: FF->FE, latency measured from first sampling edge
        b_lv = cnt_lv;
        first_hit = 0;
        @(negedge clk);
        led_in = 8'hFE;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (level_valid && first_hit == 0) first_hit = i;
        end
        chk("t2_latency_edge", first_hit, 7);
        chk("t2_pulses", cnt_lv - b_lv, 1);
        chk("t2_level", level, 1);

        // 3: short glitch back to the accepted pattern
        b_lv = cnt_lv; b_ie = cnt_ie;
        hold(8'hFC, 2);
        hold(8'hFE, 10);
        chk("t3_lv", cnt_lv - b_lv, 0);
        chk("t3_ie", cnt_ie - b_ie, 0);
        chk("t3_level", level, 1);

        // 4: full sweep with wrap
        do_reset();
        b_lv = cnt_lv; b_se = cnt_se;
        hold(8'hFF, 10);
        for (int i = 0; i < 9; i++) begin
            hold(seq_pat[i], 10);
            chk($sformatf("t4_level_%0d", i), level, (i + 1) % 9);
        end
        chk("t4_pulses", cnt_lv - b_lv, 9);
        chk("t4_wrap", wrap_cnt, 1);
        chk("t4_seq", cnt_se - b_se, 0);

        // 5: invalid pattern, then a skipped level
        hold(8'hFE, 10);
        chk("t5_pre_level", level, 1);
        b_lv = cnt_lv; b_ie = cnt_ie; b_se = cnt_se;
        hold(8'hF5, 10);
        chk("t5_ie", cnt_ie - b_ie, 1);
        chk("t5_lv_on_bad", cnt_lv - b_lv, 0);
        chk("t5_level_hold", level, 1);
        hold(8'hF8, 10);
        chk("t5_level", level, 3);
        chk("t5_seq", cnt_se - b_se, SEQ_ON);
        chk("t5_wrap_kept", wrap_cnt, 1);

        // 6: reset asserted mid-filter
        do_reset();
        hold(8'hFE, 10);
        hold(8'hFC, 10);
        chk("t6_pre_level", level, 2);
        @(negedge clk);
        led_in = 8'hF8;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_level", level, 0);
        chk("t6_rst_wrap", wrap_cnt, 0);
        repeat (2) @(negedge clk);
        b_lv = cnt_lv; b_se = cnt_se;
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_level", level, 3);
        chk("t6_lv", cnt_lv - b_lv, 1);
        chk("t6_seq", cnt_se - b_se, SEQ_ON);
        chk("excl_pulses", cnt_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
